store_buffer: RTL

// - Responder for the decode-stage data-memory request channel (mem_valid/fence/spec/instr/addr/wdata/wstrb).
// - Posts stores into a DEPTH-entry FIFO and drains them in order to the data-memory port.
// - Loads issue ahead of queued stores unless their word address hits the buffer.
// - Fences complete only once the buffer is empty. The block sits between the decode stage and the data memory/cache.

---
 rtl/store_buffer_if.sv | 34 +++
 rtl/store_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - decode-side request channel and data-memory port of the store buffer
interface store_buffer_if;
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        dmem_valid;
    logic        dmem_instr;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport slave (
        input  mem_valid, mem_fence, mem_spec, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport master (
        output mem_valid, mem_fence, mem_spec, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO between decode and data memory; loads bypass unless they hit.
// Optional store-to-load forwarding of full-word entries: define STOREBUFFER_FWD_EN.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;
    state_t state;

    logic [31:0]      ent_addr  [DEPTH];
    logic [31:0]      ent_wdata [DEPTH];
    logic [3:0]       ent_wstrb [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic        pend_valid;
    logic        pend_fence;
    logic        pend_instr;
    logic [31:0] pend_addr;
    logic [31:0] pend_wdata;
    logic [3:0]  pend_wstrb;

    logic        req_store;
    logic        not_full;
    logic        direct_enq;
    logic        pend_enq;
    logic        enq;
    logic        deq;
    logic        hazard;
    logic        load_go;
    logic        fence_done;
    logic [31:0] enq_addr;
    logic [31:0] enq_wdata;
    logic [3:0]  enq_wstrb;

    assign req_store  = !bus.mem_fence && (bus.mem_wstrb != 4'h0);
    assign not_full   = count < CNT_W'(DEPTH);
    assign direct_enq = bus.mem_valid && !pend_valid && req_store && not_full;
    assign pend_enq   = pend_valid && !pend_fence && (pend_wstrb != 4'h0) && not_full;
    assign enq        = direct_enq || pend_enq;
    assign deq        = (state == STORE) && bus.dmem_ready;
    assign enq_addr   = pend_valid ? pend_addr  : bus.mem_addr;
    assign enq_wdata  = pend_valid ? pend_wdata : bus.mem_wdata;
    assign enq_wstrb  = pend_valid ? pend_wstrb : bus.mem_wstrb;
    assign load_go    = pend_valid && !pend_fence && (pend_wstrb == 4'h0) && (pend_instr || !hazard);
    assign fence_done = (count == '0) && (state == IDLE);

    // Word-granular hit against every occupied slot, walked from the head.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_addr[idx][31:2] == pend_addr[31:2]))
                hazard = 1'b1;
        end
    end

`ifdef STOREBUFFER_FWD_EN
    logic        fwd_hit;
    logic [31:0] fwd_data;

    // Later slots overwrite earlier ones, so the youngest matching store decides.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_addr[idx][31:2] == bus.mem_addr[31:2])) begin
                fwd_hit  = (ent_wstrb[idx] == 4'hF);
                fwd_data = ent_wdata[idx];
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (enq) begin
            ent_addr[tail]  <= enq_addr;
            ent_wdata[tail] <= enq_wdata;
            ent_wstrb[tail] <= enq_wstrb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            pend_valid     <= 1'b0;
            pend_fence     <= 1'b0;
            pend_instr     <= 1'b0;
            pend_addr      <= '0;
            pend_wdata     <= '0;
            pend_wstrb     <= '0;
            bus.mem_ready  <= 1'b0;
            bus.mem_rdata  <= '0;
            bus.dmem_valid <= 1'b0;
            bus.dmem_instr <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.dmem_wstrb <= '0;
        end else begin
            bus.mem_ready <= 1'b0;
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);

            if (!pend_valid && bus.mem_valid) begin
                if (req_store && not_full) begin
                    bus.mem_ready <= 1'b1;
                end else if (bus.mem_fence && fence_done) begin
                    bus.mem_ready <= 1'b1;
`ifdef STOREBUFFER_FWD_EN
                end else if (!req_store && !bus.mem_fence && !bus.mem_instr && fwd_hit) begin
                    bus.mem_ready <= 1'b1;
                    bus.mem_rdata <= fwd_data;
`endif
                end else begin
                    pend_valid <= 1'b1;
                    pend_fence <= bus.mem_fence;
                    pend_instr <= bus.mem_instr;
                    pend_addr  <= bus.mem_addr;
                    pend_wdata <= bus.mem_wdata;
                    pend_wstrb <= bus.mem_fence ? 4'h0 : bus.mem_wstrb;
                end
            end

            if (pend_enq || (pend_valid && pend_fence && fence_done)) begin
                pend_valid    <= 1'b0;
                bus.mem_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load_go) begin
                        state          <= LOAD;
                        bus.dmem_valid <= 1'b1;
                        bus.dmem_instr <= pend_instr;
                        bus.dmem_addr  <= pend_addr;
                        bus.dmem_wdata <= '0;
                        bus.dmem_wstrb <= 4'h0;
                    end else if (count != '0) begin
                        state          <= STORE;
                        bus.dmem_valid <= 1'b1;
                        bus.dmem_instr <= 1'b0;
                        bus.dmem_addr  <= ent_addr[head];
                        bus.dmem_wdata <= ent_wdata[head];
                        bus.dmem_wstrb <= ent_wstrb[head];
                    end
                end
                LOAD: begin
                    if (bus.dmem_ready) begin
                        state          <= IDLE;
                        bus.dmem_valid <= 1'b0;
                        bus.mem_ready  <= 1'b1;
                        bus.mem_rdata  <= bus.dmem_rdata;
                        pend_valid     <= 1'b0;
                    end
                end
                STORE: begin
                    if (bus.dmem_ready) begin
                        state          <= IDLE;
                        bus.dmem_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
